rw_addr_sched_k2: RTL

Consumes the translated index stream of the radix-2 address generation stage: MA/BN pairs, out-enable, done and stage number. Issues conflict-free reads to the two data memory banks and replays the same addresses as write-backs after a fixed butterfly latency. Tracks stage completion and reports errors. Sits between the AGU top and the bank memories / butterfly unit.

---
 rtl/rw_addr_sched_k2_pkg.sv | 26 ++
 rtl/rw_addr_sched_k2_wb_delay_line.sv | 39 +++
 rtl/rw_addr_sched_k2.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/rw_addr_sched_k2_pkg.sv
// Shared types and defaults for the radix-2 read/write address scheduler.
package rw_addr_sched_k2_pkg;

  // Index width used by the AGU stream; the write-back entry is sized from it.
  localparam int K2_D_WIDTH = 32;
  // Default butterfly latency from read-data-valid to write-data-valid.
  localparam int K2_BF_LAT  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } sched_state_e;

  // One in-flight butterfly: which banks were read and at which addresses,
  // so the same accesses can be replayed as write-backs.
  typedef struct packed {
    logic                  valid;
    logic [K2_D_WIDTH-1:0] addr0;
    logic [K2_D_WIDTH-1:0] addr1;
    logic                  en0;
    logic                  en1;
    logic                  swap;
  } wb_entry_t;

endpackage

// File: rtl/rw_addr_sched_k2_wb_delay_line.sv
// Fixed-depth shift register carrying read accesses forward to their write-back slot.
module wb_delay_line_k2
  import rw_addr_sched_k2_pkg::*;
#(
  parameter int DEPTH = K2_BF_LAT
) (
  input  logic             clk,
  input  logic             rst,
  input  wb_entry_t        din,
  output wb_entry_t        dout,
  output logic [DEPTH-1:0] valid_vec
);

  wb_entry_t stage_reg [DEPTH];

  // Shift every cycle; reset empties the line so no stale write-back escapes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_reg[i] <= '0;
      end
    end else begin
      stage_reg[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_valid
      assign valid_vec[gi] = stage_reg[gi].valid;
    end
  endgenerate

  assign dout = stage_reg[DEPTH-1];

endmodule

// File: rtl/rw_addr_sched_k2.sv
// Radix-2 read/write address scheduler: conflict-free bank reads, delayed write-back
// replay, stage completion tracking and sticky error reporting.
module rw_addr_sched_k2
  import rw_addr_sched_k2_pkg::*;
#(
  parameter int D_WIDTH = K2_D_WIDTH,
  parameter int BF_LAT  = K2_BF_LAT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [D_WIDTH-1:0] MA0_idx_k2,
  input  logic [D_WIDTH-1:0] MA1_idx_k2,
  input  logic [D_WIDTH-1:0] BN0_idx_k2,
  input  logic [D_WIDTH-1:0] BN1_idx_k2,
  input  logic               BN_MA_out_en_k2,
  input  logic               AGU_done_out_k2,
  input  logic [D_WIDTH-1:0] l_AGU_out_k2,
  output logic               bank0_rd_en,
  output logic               bank1_rd_en,
  output logic [D_WIDTH-1:0] bank0_rd_addr,
  output logic [D_WIDTH-1:0] bank1_rd_addr,
  output logic               rd_swap,
  output logic [D_WIDTH-1:0] l_rd_out,
  output logic               bank0_wr_en,
  output logic               bank1_wr_en,
  output logic [D_WIDTH-1:0] bank0_wr_addr,
  output logic [D_WIDTH-1:0] bank1_wr_addr,
  output logic               wr_swap,
  output logic               sched_done,
  output logic               busy,
  output logic [D_WIDTH-1:0] pair_cnt,
  output logic               conflict_err,
  output logic               seq_err
);

  localparam logic [3:0] DRAIN_LOAD = 4'(BF_LAT);

  logic               en;
  logic               done;
  logic               bn0;
  logic               bn1;
  logic               conflict;
  logic               unused_bn_bits;

  logic               rd_en0_reg;
  logic               rd_en1_reg;
  logic [D_WIDTH-1:0] rd_addr0_reg;
  logic [D_WIDTH-1:0] rd_addr1_reg;
  logic               rd_swap_reg;
  logic [D_WIDTH-1:0] l_rd_reg;

  wb_entry_t          wb_in;
  wb_entry_t          wb_out;
  logic [BF_LAT-1:0]  wb_valid_vec;

  sched_state_e       state_reg;
  sched_state_e       state_next;
  logic [3:0]         drain_cnt_reg;
  logic [3:0]         drain_cnt_next;
  logic [D_WIDTH-1:0] pair_cnt_reg;
  logic [D_WIDTH-1:0] pair_cnt_next;
  logic               conflict_err_reg;
  logic               conflict_err_next;
  logic               seq_err_reg;
  logic               seq_err_next;
  logic               sched_done_c;

  assign en       = BN_MA_out_en_k2;
  assign done     = AGU_done_out_k2;
  assign bn0      = BN0_idx_k2[0];
  assign bn1      = BN1_idx_k2[0];
  assign conflict = (bn0 == bn1);
  // Only the bank-select LSB is meaningful on the BN inputs.
  assign unused_bn_bits = ^{BN0_idx_k2[D_WIDTH-1:1], BN1_idx_k2[D_WIDTH-1:1]};

  // Read stage: steer each operand to its bank; a conflicting pair issues operand 0 only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_en0_reg   <= 1'b0;
      rd_en1_reg   <= 1'b0;
      rd_addr0_reg <= '0;
      rd_addr1_reg <= '0;
      rd_swap_reg  <= 1'b0;
      l_rd_reg     <= '0;
    end else begin
      rd_en0_reg <= 1'b0;
      rd_en1_reg <= 1'b0;
      if (en) begin
        rd_swap_reg <= bn0;
        l_rd_reg    <= l_AGU_out_k2;
        if (bn0) begin
          rd_en1_reg   <= 1'b1;
          rd_addr1_reg <= MA0_idx_k2;
        end else begin
          rd_en0_reg   <= 1'b1;
          rd_addr0_reg <= MA0_idx_k2;
        end
        if (!conflict) begin
          if (bn1) begin
            rd_en1_reg   <= 1'b1;
            rd_addr1_reg <= MA1_idx_k2;
          end else begin
            rd_en0_reg   <= 1'b1;
            rd_addr0_reg <= MA1_idx_k2;
          end
        end
      end
    end
  end

  // Pack the issued read into a write-back entry for the delay line.
  always_comb begin
    wb_in       = '0;
    wb_in.valid = rd_en0_reg | rd_en1_reg;
    wb_in.addr0 = rd_addr0_reg;
    wb_in.addr1 = rd_addr1_reg;
    wb_in.en0   = rd_en0_reg;
    wb_in.en1   = rd_en1_reg;
    wb_in.swap  = rd_swap_reg;
  end

  wb_delay_line_k2 #(
    .DEPTH (BF_LAT)
  ) u_wb_delay (
    .clk       (clk),
    .rst       (rst),
    .din       (wb_in),
    .dout      (wb_out),
    .valid_vec (wb_valid_vec)
  );

  // Stage tracking state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      drain_cnt_reg    <= '0;
      pair_cnt_reg     <= '0;
      conflict_err_reg <= 1'b0;
      seq_err_reg      <= 1'b0;
    end else begin
      state_reg        <= state_next;
      drain_cnt_reg    <= drain_cnt_next;
      pair_cnt_reg     <= pair_cnt_next;
      conflict_err_reg <= conflict_err_next;
      seq_err_reg      <= seq_err_next;
    end
  end

  // Next-state: drain waits out the butterfly latency so sched_done lines up with
  // the write-back of the last pair of the stage.
  always_comb begin
    state_next        = state_reg;
    drain_cnt_next    = drain_cnt_reg;
    pair_cnt_next     = pair_cnt_reg;
    conflict_err_next = conflict_err_reg;
    seq_err_next      = seq_err_reg;
    sched_done_c      = 1'b0;

    if (en && conflict) begin
      conflict_err_next = 1'b1;
    end

    case (state_reg)
      IDLE: begin
        if (done) begin
          state_next     = DRAIN;
          drain_cnt_next = DRAIN_LOAD;
          pair_cnt_next  = en ? D_WIDTH'(1) : '0;
        end else if (en) begin
          state_next    = RUN;
          pair_cnt_next = D_WIDTH'(1);
        end
      end
      RUN: begin
        if (en) begin
          pair_cnt_next = pair_cnt_reg + D_WIDTH'(1);
        end
        if (done) begin
          state_next     = DRAIN;
          drain_cnt_next = DRAIN_LOAD;
        end
      end
      DRAIN: begin
        if (en) begin
          pair_cnt_next = pair_cnt_reg + D_WIDTH'(1);
        end
        if (en || done) begin
          seq_err_next = 1'b1;
        end
        if (drain_cnt_reg == 4'd0) begin
          sched_done_c = 1'b1;
          state_next   = IDLE;
        end else begin
          drain_cnt_next = drain_cnt_reg - 4'd1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bank0_rd_en   = rd_en0_reg;
  assign bank1_rd_en   = rd_en1_reg;
  assign bank0_rd_addr = rd_addr0_reg;
  assign bank1_rd_addr = rd_addr1_reg;
  assign rd_swap       = rd_swap_reg;
  assign l_rd_out      = l_rd_reg;

  assign bank0_wr_en   = wb_out.valid & wb_out.en0;
  assign bank1_wr_en   = wb_out.valid & wb_out.en1;
  assign bank0_wr_addr = wb_out.addr0;
  assign bank1_wr_addr = wb_out.addr1;
  assign wr_swap       = wb_out.swap;

  assign sched_done    = sched_done_c;
  assign busy          = (state_reg != IDLE) | rd_en0_reg | rd_en1_reg | (|wb_valid_vec);
  assign pair_cnt      = pair_cnt_reg;
  assign conflict_err  = conflict_err_reg;
  assign seq_err       = seq_err_reg;

endmodule
